// File: rtl/lut_layer_sched_if.sv
// Stream and configuration bundle for lut_layer_sched.
//   cfg_*   : configuration write port into the truth-table RAM / connectivity table,
//             cfg_err is the one-cycle "write rejected" pulse coming back.
//   s_*     : input activation vector (valid/ready).
//   m_*     : output activation vector (valid/ready), bit n = neuron n.
// Modports: master = the side that drives vectors and config (upstream/testbench),
//           slave  = the scheduler.
interface lut_layer_sched_if #(
  parameter int IN_WIDTH  = 64,
  parameter int N_NEURONS = 16,
  parameter int FANIN     = 8,
  parameter int IDX_W     = 6
);
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  logic                 cfg_we;
  logic                 cfg_sel;
  logic [NW-1:0]        cfg_neuron;
  logic [FANIN-1:0]     cfg_addr;
  logic [IDX_W-1:0]     cfg_data;
  logic                 cfg_err;

  logic                 s_valid;
  logic                 s_ready;
  logic [IN_WIDTH-1:0]  s_data;

  logic                 m_valid;
  logic                 m_ready;
  logic [N_NEURONS-1:0] m_data;

  modport master (
    output cfg_we, cfg_sel, cfg_neuron, cfg_addr, cfg_data,
    output s_valid, s_data, m_ready,
    input  cfg_err, s_ready, m_valid, m_data
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_neuron, cfg_addr, cfg_data,
    input  s_valid, s_data, m_ready,
    output cfg_err, s_ready, m_valid, m_data
  );
endinterface

// File: rtl/lut_layer_sched.sv
// Time-multiplexed evaluator for one LogicNets LUT layer.
// One shared truth-table RAM (N_NEURONS x 2**FANIN x 1) replaces the per-neuron LUT ROMs.
// For every accepted input vector the neurons are visited in order: the fan-in bits of
// neuron n are gathered through the connectivity table, concatenated into a LUT address
// and looked up; the looked-up bit lands in m_data[n] one cycle later.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset (aborts any pass in flight)
//   bus   : lut_layer_sched_if.slave (config port, input stream, output stream)
//   busy  : high whenever the scheduler is not idle
module lut_layer_sched #(
  parameter int IN_WIDTH  = 64,
  parameter int N_NEURONS = 16,
  parameter int FANIN     = 8,
  parameter int IDX_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  lut_layer_sched_if.slave  bus,
  output logic              busy
);
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int KW = (FANIN > 1) ? $clog2(FANIN) : 1;
  localparam int IW = $clog2(IN_WIDTH);
  localparam logic [NW-1:0] LAST_N = NW'(N_NEURONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_e;

  state_e               state_q, state_d;
  logic [NW-1:0]        n_q, n_d;
  logic [NW-1:0]        prev_n;
  logic [IN_WIDTH-1:0]  in_q, in_d;
  logic [N_NEURONS-1:0] m_data_q, m_data_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 tt_mem   [N_NEURONS][2**FANIN];
  logic [IDX_W-1:0]     conn_mem [N_NEURONS][FANIN];
  logic                 rd_bit_q;
  logic [FANIN-1:0]     lut_addr;
  logic                 slot_ok;
  logic                 cfg_ok;

  // Fan-in gather for the neuron being issued. Indices past the input vector read as 0.
  always_comb begin
    lut_addr = '0;
    for (int k = 0; k < FANIN; k++) begin
      if (int'(conn_mem[n_q][k]) < IN_WIDTH) begin
        lut_addr[k] = in_q[conn_mem[n_q][k][IW-1:0]];
      end
    end
  end

  // Config writes land only while idle and not colliding with a vector accept.
  // A connectivity slot outside [0,FANIN) has no storage and is rejected as well.
  assign slot_ok = (int'(bus.cfg_addr) < FANIN);
  assign cfg_ok  = bus.cfg_we && (state_q == S_IDLE) && !bus.s_valid
                   && (!bus.cfg_sel || slot_ok);

  // NOTE: the tables and the RAM read register have no reset; clearing a RAM would
  // force it out of distributed/block memory and into plain flops.
  always_ff @(posedge clk) begin
    if (cfg_ok && !bus.cfg_sel) tt_mem[bus.cfg_neuron][bus.cfg_addr] <= bus.cfg_data[0];
    if (cfg_ok && bus.cfg_sel)  conn_mem[bus.cfg_neuron][bus.cfg_addr[KW-1:0]] <= bus.cfg_data;
    rd_bit_q <= tt_mem[n_q][lut_addr];
  end

  assign prev_n = n_q - NW'(1);

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    n_d       = n_q;
    in_d      = in_q;
    m_data_d  = m_data_q;
    cfg_err_d = bus.cfg_we && !cfg_ok;

    unique case (state_q)
      S_IDLE: begin
        if (bus.s_valid) begin
          in_d    = bus.s_data;
          n_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The RAM answers one cycle late: the bit arriving now belongs to neuron n-1.
        if (n_q != '0) m_data_d[prev_n] = rd_bit_q;
        n_d = n_q + NW'(1);
        if (n_q == LAST_N) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        m_data_d[N_NEURONS-1] = rd_bit_q;
        state_d               = S_OUT;
      end
      S_OUT: begin
        if (bus.m_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      in_q      <= '0;
      m_data_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      in_q      <= in_d;
      m_data_q  <= m_data_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.s_ready = (state_q == S_IDLE);
  assign bus.m_valid = (state_q == S_OUT);
  assign bus.m_data  = m_data_q;
  assign bus.cfg_err = cfg_err_q;
  assign busy        = (state_q != S_IDLE);
endmodule
